// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle controller: fill, heat, wash, N rinses, spin, done,
// with sensor timeouts, door-open pause/resume and abort-to-drain.
module wash_cycle_ctrl #(
  parameter int TW          = 8,
  parameter int FILL_MAX    = 10,
  parameter int HEAT_MAX    = 12,
  parameter int WASH_TICKS  = 6,
  parameter int DRAIN_MAX   = 8,
  parameter int RINSE_TICKS = 4,
  parameter int RINSES      = 2,
  parameter int SPIN_TICKS  = 5,
  parameter int BEEP_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       door_closed,
  input  logic       start,
  input  logic       abort,
  input  logic       temp_ok,
  input  logic       level_full,
  input  logic       level_empty,
  input  logic       quiet,
  output logic       fill_valve,
  output logic       heater,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       drain_pump,
  output logic       door_lock,
  output logic       beep,
  output logic       done,
  output logic       error,
  output logic [3:0] state_o,
  output logic [2:0] rinse_left
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_HEAT   = 4'd2,
    S_WASH   = 4'd3,
    S_DRAIN  = 4'd4,
    S_RFILL  = 4'd5,
    S_RINSE  = 4'd6,
    S_RDRAIN = 4'd7,
    S_SPIN   = 4'd8,
    S_DONE   = 4'd9,
    S_ERROR  = 4'd10,
    S_PAUSE  = 4'd11
  } state_t;

  state_t          r_state;
  state_t          r_saved_state;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   r_saved_timer;
  logic [2:0]      r_rinse_left;
  logic            r_abort_flag;

  state_t          w_next_state;
  state_t          w_next_saved_state;
  state_t          w_drain_exit;
  logic [TW-1:0]   w_next_timer;
  logic [TW-1:0]   w_next_saved_timer;
  logic [2:0]      w_next_rinse;
  logic            w_next_flag;
  logic            w_restore;
  logic            w_force_clear;
  logic            w_locked;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // True on the tick edge that completes an N-tick interval.
  function automatic logic expired(input logic tk, input logic [TW-1:0] t, input int n);
    return tk && (t == TW'(n - 1));
  endfunction

  assign w_locked     = (r_state >= S_FILL) && (r_state <= S_SPIN);
  assign w_drain_exit = r_abort_flag          ? S_IDLE  :
                        (r_rinse_left != 3'd0) ? S_RFILL : S_SPIN;

  always_comb begin
    w_next_state       = r_state;
    w_next_rinse       = r_rinse_left;
    w_next_flag        = r_abort_flag;
    w_next_saved_state = r_saved_state;
    w_next_saved_timer = r_saved_timer;
    w_restore          = 1'b0;
    w_force_clear      = 1'b0;

    if (abort && (r_state != S_IDLE) && (r_state != S_ERROR)) begin
      w_next_state  = S_DRAIN;
      w_next_rinse  = 3'd0;
      w_next_flag   = 1'b1;
      w_force_clear = 1'b1;
    end else if (!door_closed && w_locked) begin
      w_next_state       = S_PAUSE;
      w_next_saved_state = r_state;
      w_next_saved_timer = r_timer;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next_flag = 1'b0;
          if (door_closed && start) begin
            w_next_state = S_FILL;
            w_next_rinse = 3'(RINSES);
          end
        end
        S_FILL: begin
          if (level_full)                            w_next_state = S_HEAT;
          else if (expired(tick, r_timer, FILL_MAX)) w_next_state = S_ERROR;
        end
        S_HEAT: begin
          if (temp_ok)                               w_next_state = S_WASH;
          else if (expired(tick, r_timer, HEAT_MAX)) w_next_state = S_ERROR;
        end
        S_WASH: begin
          if (expired(tick, r_timer, WASH_TICKS)) w_next_state = S_DRAIN;
        end
        S_DRAIN, S_RDRAIN: begin
          if (level_empty)                            w_next_state = w_drain_exit;
          else if (expired(tick, r_timer, DRAIN_MAX)) w_next_state = S_ERROR;
        end
        S_RFILL: begin
          if (level_full)                            w_next_state = S_RINSE;
          else if (expired(tick, r_timer, FILL_MAX)) w_next_state = S_ERROR;
        end
        S_RINSE: begin
          if (expired(tick, r_timer, RINSE_TICKS)) begin
            w_next_state = S_RDRAIN;
            w_next_rinse = r_rinse_left - 3'd1;
          end
        end
        S_SPIN: begin
          if (expired(tick, r_timer, SPIN_TICKS)) w_next_state = S_DONE;
        end
        S_DONE: begin
          if (!door_closed) w_next_state = S_IDLE;
        end
        S_ERROR: begin
          if (abort && level_empty) w_next_state = S_IDLE;
        end
        S_PAUSE: begin
          if (door_closed && start) begin
            w_next_state = r_saved_state;
            w_restore    = 1'b1;
          end
        end
        default: w_next_state = S_ERROR;
      endcase
    end
  end

  // Abort re-enters DRAIN even from DRAIN, so entry is not just a state change.
  always_comb begin
    if (w_restore)                                   w_next_timer = r_saved_timer;
    else if ((w_next_state != r_state) || w_force_clear) w_next_timer = '0;
    else if (tick)                                   w_next_timer = sat_inc(r_timer);
    else                                             w_next_timer = r_timer;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_saved_state <= S_IDLE;
      r_timer       <= '0;
      r_saved_timer <= '0;
      r_rinse_left  <= 3'd0;
      r_abort_flag  <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_saved_state <= w_next_saved_state;
      r_timer       <= w_next_timer;
      r_saved_timer <= w_next_saved_timer;
      r_rinse_left  <= w_next_rinse;
      r_abort_flag  <= w_next_flag;
    end
  end

  // Moore decode; only beep additionally looks at the quiet input.
  always_comb begin
    fill_valve = (r_state == S_FILL) || (r_state == S_RFILL);
    heater     = (r_state == S_HEAT);
    motor_wash = (r_state == S_WASH) || (r_state == S_RINSE);
    motor_spin = (r_state == S_SPIN);
    drain_pump = (r_state == S_DRAIN) || (r_state == S_RDRAIN) || (r_state == S_ERROR);
    door_lock  = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_PAUSE);
    done       = (r_state == S_DONE);
    error      = (r_state == S_ERROR);
    beep       = ((r_state == S_DONE) || (r_state == S_ERROR)) &&
                 (r_timer < TW'(BEEP_TICKS)) && !quiet;
  end

  assign state_o    = r_state;
  assign rinse_left = r_rinse_left;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: every-cycle comparison against a behavioural model,
// directed scenarios with literal expectations, then randomized sensor/door/abort traffic.
module tb_wash_cycle_ctrl;
  localparam int TW = 8, FILL_MAX = 10, HEAT_MAX = 12, WASH_TICKS = 6, DRAIN_MAX = 8;
  localparam int RINSE_TICKS = 4, RINSES = 2, SPIN_TICKS = 5, BEEP_TICKS = 3;
  localparam int TMAX = (1 << TW) - 1;

  logic clk = 0, reset = 1, tick = 0, door_closed = 1, start = 0, abort = 0;
  logic temp_ok = 0, level_full = 0, level_empty = 0, quiet = 0;
  logic fill_valve, heater, motor_wash, motor_spin, drain_pump, door_lock, beep, done, error;
  logic [3:0] state_o;
  logic [2:0] rinse_left;

  int checks = 0, errors = 0;

  wash_cycle_ctrl #(.TW(TW), .FILL_MAX(FILL_MAX), .HEAT_MAX(HEAT_MAX), .WASH_TICKS(WASH_TICKS),
    .DRAIN_MAX(DRAIN_MAX), .RINSE_TICKS(RINSE_TICKS), .RINSES(RINSES), .SPIN_TICKS(SPIN_TICKS),
    .BEEP_TICKS(BEEP_TICKS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .door_closed(door_closed), .start(start),
    .abort(abort), .temp_ok(temp_ok), .level_full(level_full), .level_empty(level_empty),
    .quiet(quiet), .fill_valve(fill_valve), .heater(heater), .motor_wash(motor_wash),
    .motor_spin(motor_spin), .drain_pump(drain_pump), .door_lock(door_lock), .beep(beep),
    .done(done), .error(error), .state_o(state_o), .rinse_left(rinse_left));

  always #5 clk = ~clk;

  // Behavioural model: state code, tick count in state, rinses left, abort flag, pause snapshot.
  int m_st = 0, m_tmr = 0, m_rl = 0, m_flag = 0, m_svst = 0, m_svtmr = 0;
  bit m_valid = 0;

  function automatic int limit(input int st);
    case (st)
      1, 5: return FILL_MAX;
      2:    return HEAT_MAX;
      3:    return WASH_TICKS;
      4, 7: return DRAIN_MAX;
      6:    return RINSE_TICKS;
      8:    return SPIN_TICKS;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int nst = m_st, nrl = m_rl, nflag = m_flag, nsvst = m_svst, nsvtmr = m_svtmr, ntmr;
    bit clr = 0, restore = 0;
    bit up = tick && (limit(m_st) > 0) && (m_tmr == limit(m_st) - 1);
    if (abort && m_st != 0 && m_st != 10) begin
      nst = 4; nrl = 0; nflag = 1; clr = 1;
    end else if (!door_closed && m_st >= 1 && m_st <= 8) begin
      nst = 11; nsvst = m_st; nsvtmr = m_tmr;
    end else begin
      case (m_st)
        0: begin nflag = 0; if (door_closed && start) begin nst = 1; nrl = RINSES; end end
        1, 5: if (level_full) nst = m_st + 1; else if (up) nst = 10;
        2: if (temp_ok) nst = 3; else if (up) nst = 10;
        3: if (up) nst = 4;
        4, 7: if (level_empty) nst = m_flag ? 0 : (m_rl > 0 ? 5 : 8); else if (up) nst = 10;
        6: if (up) begin nst = 7; nrl = m_rl - 1; end
        8: if (up) nst = 9;
        9: if (!door_closed) nst = 0;
        10: if (abort && level_empty) nst = 0;
        11: if (door_closed && start) begin nst = m_svst; restore = 1; end
        default: nst = 10;
      endcase
    end
    if (restore) ntmr = m_svtmr;
    else if (nst != m_st || clr) ntmr = 0;
    else if (tick && m_tmr < TMAX) ntmr = m_tmr + 1;
    else ntmr = m_tmr;
    m_st = nst; m_tmr = ntmr; m_rl = nrl & 7; m_flag = nflag; m_svst = nsvst; m_svtmr = nsvtmr;
  endtask

  function automatic logic [15:0] exp_vec();
    logic fv, ht, mw, ms, dp, lk, bp, dn, er;
    fv = (m_st == 1 || m_st == 5);
    ht = (m_st == 2);
    mw = (m_st == 3 || m_st == 6);
    ms = (m_st == 8);
    dp = (m_st == 4 || m_st == 7 || m_st == 10);
    lk = !(m_st == 0 || m_st == 9 || m_st == 11);
    bp = (m_st == 9 || m_st == 10) && (m_tmr < BEEP_TICKS) && !quiet;
    dn = (m_st == 9);
    er = (m_st == 10);
    return {fv, ht, mw, ms, dp, lk, bp, dn, er, 4'(m_st), 3'(m_rl)};
  endfunction

  logic [15:0] dut_vec;
  assign dut_vec = {fill_valve, heater, motor_wash, motor_spin, drain_pump, door_lock, beep,
                    done, error, state_o, rinse_left};

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_tmr = 0; m_rl = 0; m_flag = 0; m_svst = 0; m_svtmr = 0; m_valid = 1;
    end else if (m_valid) begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL outputs @%0t: got %h want %h (model state %0d timer %0d)",
                 $time, dut_vec, exp_vec(), m_st, m_tmr);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Plant: sensors answer p_delay ticks after the DUT enters the relevant state.
  int p_cnt = 0, p_delay = 2;
  int p_last = 0;
  bit rec = 0;
  int seq[$];

  task automatic next();
    @(negedge clk); #2;
  endtask

  task automatic plant_cycle(input bit t);
    tick        = t;
    level_full  = (state_o == 1 || state_o == 5) && p_cnt >= p_delay;
    temp_ok     = (state_o == 2) && p_cnt >= p_delay;
    level_empty = (state_o == 4 || state_o == 7 || state_o == 10) && p_cnt >= p_delay;
    next();
    if (int'(state_o) != p_last) begin
      if (rec) seq.push_back(int'(state_o));
      p_cnt = 0; p_last = int'(state_o);
    end else if (t) begin
      p_cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1; start = 0; abort = 0; tick = 0; door_closed = 1; quiet = 0;
    level_full = 0; level_empty = 0; temp_ok = 0;
    next();
    reset = 0; p_cnt = 0; p_last = 0;
  endtask

  task automatic run_to(input int code, input int budget);
    int k = 0;
    while (int'(state_o) != code && k < budget) begin plant_cycle(bit'(k % 2)); k++; end
    chk($sformatf("reach_state_%0d", code), state_o, code);
  endtask

  initial begin
    int n, k, bticks, spin_seen;
    int exp1[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 5, 6, 7, 8, 9};
    next(); do_reset();
    chk("reset_state", state_o, 0);
    chk("reset_outputs", dut_vec, 0);

    // Full cycle with two rinses.
    p_delay = 2; rec = 1; seq.delete(); seq.push_back(0);
    start = 1; plant_cycle(0); start = 0;
    run_to(9, 600);
    rec = 0;
    chk("seq_len", seq.size(), 13);
    for (int i = 0; i < 13; i++)
      if (i < seq.size()) chk($sformatf("seq[%0d]", i), seq[i], exp1[i]);
    bticks = 0;
    for (int i = 0; i < 12; i++) begin
      if (beep && (i % 2 == 1)) bticks++;
      plant_cycle(bit'(i % 2));
    end
    chk("done_flag", done, 1);
    chk("beep_ticks", bticks, 3);

    // Fill timeout.
    do_reset(); p_delay = 1000;
    start = 1; plant_cycle(0); start = 0;
    n = 0; k = 0;
    while (state_o == 1 && k < 200) begin
      if (k % 2 == 1) n++;
      plant_cycle(bit'(k % 2)); k++;
    end
    chk("fill_timeout_ticks", n, 10);
    chk("err_state", state_o, 10);
    chk("err_flag", error, 1);
    chk("err_drain", drain_pump, 1);
    chk("err_fill_off", fill_valve, 0);
    p_delay = 0; abort = 1; plant_cycle(0); abort = 0;
    chk("err_exit_idle", state_o, 0);

    // Pause in WASH at timer 3, resume, 3 more ticks.
    do_reset(); p_delay = 2;
    start = 1; plant_cycle(0); start = 0;
    run_to(3, 300);
    n = 0; k = 0;
    while (n < 3 && k < 100) begin
      if (k % 2 == 1) n++;
      plant_cycle(bit'(k % 2)); k++;
    end
    chk("wash_still", state_o, 3);
    door_closed = 0; plant_cycle(0);
    chk("pause_state", state_o, 11);
    chk("pause_motor", motor_wash, 0);
    plant_cycle(1); plant_cycle(0);
    door_closed = 1; start = 1; plant_cycle(0); start = 0;
    chk("resume_state", state_o, 3);
    n = 0; k = 0;
    while (state_o == 3 && k < 100) begin
      if (k % 2 == 1) n++;
      plant_cycle(bit'(k % 2)); k++;
    end
    chk("resume_ticks", n, 3);

    // Abort during RINSE.
    do_reset(); p_delay = 2;
    start = 1; plant_cycle(0); start = 0;
    run_to(6, 400);
    abort = 1; plant_cycle(0); abort = 0;
    chk("abort_drain", state_o, 4);
    chk("abort_rinse_left", rinse_left, 0);
    spin_seen = 0; k = 0;
    while (state_o != 0 && k < 100) begin
      if (state_o == 8) spin_seen = 1;
      plant_cycle(bit'(k % 2)); k++;
    end
    chk("abort_idle", state_o, 0);
    chk("abort_no_spin", spin_seen, 0);

    // Quiet at DONE, door opens.
    do_reset(); p_delay = 2; quiet = 1;
    start = 1; plant_cycle(0); start = 0;
    run_to(9, 600);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (beep) n++;
      plant_cycle(bit'(i % 2));
    end
    chk("quiet_beep", n, 0);
    chk("quiet_done", done, 1);
    door_closed = 0; plant_cycle(0);
    chk("door_idle", state_o, 0);
    chk("door_unlock", door_lock, 0);
    door_closed = 1; quiet = 0;

    // Reset during HEAT with tick high.
    do_reset(); p_delay = 2;
    start = 1; plant_cycle(0); start = 0;
    run_to(2, 100);
    reset = 1; tick = 1; next(); reset = 0; tick = 0;
    chk("heat_reset_state", state_o, 0);
    chk("heat_reset_outputs", dut_vec, 0);
    p_cnt = 0; p_last = 0;

    // Randomized traffic; the per-cycle comparison does the checking.
    for (int c = 0; c < 6000; c++) begin
      if (c % 40 == 0) p_delay = $urandom_range(0, 13);
      if (door_closed && $urandom_range(0, 79) == 0) door_closed = 0;
      else if (!door_closed && $urandom_range(0, 5) == 0) door_closed = 1;
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 31) == 0) quiet = ~quiet;
      reset = ($urandom_range(0, 999) == 0);
      plant_cycle(bit'($urandom_range(0, 1)));
      reset = 0;
    end
    abort = 0; start = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end
endmodule
